// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel down-count timer.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused
    } timer_state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    function automatic int unsigned presc_width(input int unsigned prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter, reload register and IDLE/RUN/PAUSED FSM.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PRESCALE = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire_now,
    output logic             expired,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned     PW     = presc_width(PRESCALE);
    localparam logic [PW-1:0]   PS_MAX = PW'(PRESCALE - 1);

    timer_state_e     state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expired_q;
    logic             tick;

    assign tick = (presc_q == PS_MAX);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        count_d    = count_q;
        reload_d   = reload_q;
        mode_d     = mode_q;
        expire_now = 1'b0;
        if (abort) begin
            state_d = StIdle;
            count_d = '0;
            presc_d = '0;
        end else if (start) begin
            count_d  = load_value;
            reload_d = load_value;
            mode_d   = auto_reload;
            presc_d  = '0;
            if (load_value == '0) begin
                expire_now = 1'b1;
                state_d    = StIdle;
            end else begin
                state_d = StRun;
            end
        end else if (state_q != StIdle) begin
            // Counting happens on every edge where pause is low, including the resume edge.
            if (pause) begin
                state_d = StPaused;
            end else begin
                state_d = StRun;
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        expire_now = 1'b1;
                        if (mode_q == MODE_RELOAD) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = StIdle;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= MODE_ONESHOT;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            expired_q <= expire_now;
        end
    end

    assign expired = expired_q;
    assign busy    = (state_q != StIdle);
    assign count   = count_q;

endmodule

// File: rtl/multi_channel_timer.sv
// N independent down-count timer channels with per-channel and summary expiry pulses.
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PRESCALE = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       auto_reload,
    input  logic [NUM_CH*CNT_W-1:0] load_value,
    output logic [NUM_CH-1:0]       expired,
    output logic                    any_expired,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CNT_W-1:0] count
);

    logic [NUM_CH-1:0] expire_now;
    logic              any_expired_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W    (CNT_W),
            .PRESCALE (PRESCALE)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .start       (start[i]),
            .abort       (abort[i]),
            .pause       (pause[i]),
            .auto_reload (auto_reload[i]),
            .load_value  (load_value[i*CNT_W +: CNT_W]),
            .expire_now  (expire_now[i]),
            .expired     (expired[i]),
            .busy        (busy[i]),
            .count       (count[i*CNT_W +: CNT_W])
        );
    end

    // Registered from the same conditions so it aligns with the per-channel pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_expired_q <= 1'b0;
        end else begin
            any_expired_q <= |expire_now;
        end
    end

    assign any_expired = any_expired_q;

endmodule
